// File: rtl/id_hazard_fwd_unit.sv
// Decode-stage operand forwarding and load-use hazard unit.
// Tracks the destinations of FWD_DEPTH in-flight instructions after ID. Each read port
// picks the youngest matching stage's result, or the register file when nothing matches.
// A load that has not reached LOAD_LAT yet raises a stall request instead of forwarding.
module id_hazard_fwd_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned FWD_DEPTH = 3,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        issue_en,
    input  logic [ADDR_W-1:0]           issue_dst_addr,
    input  logic                        issue_gpr_we_,
    input  logic                        issue_is_load,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    input  logic [NUM_RD*DATA_W-1:0]    rd_gpr_data,
    input  logic [FWD_DEPTH*DATA_W-1:0] fwd_data,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic                        ld_hazard,
    output logic [CNT_W-1:0]            stall_cnt,
    input  logic                        cnt_clr
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // Tracker entry k describes the instruction sitting k stages after ID (0 = EX).
    logic              valid_q   [FWD_DEPTH];
    logic [ADDR_W-1:0] dst_q     [FWD_DEPTH];
    logic              we_n_q    [FWD_DEPTH];
    logic              is_load_q [FWD_DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [NUM_RD-1:0] port_haz;

    // Per-port operand resolution; scanning oldest to youngest lets the youngest match win.
    always_comb begin
        rd_data  = rd_gpr_data;
        port_haz = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
                if (valid_q[k] && !we_n_q[k] && (dst_q[k] == rd_addr[p*ADDR_W +: ADDR_W]) &&
                    !((ZERO_REG != 0) && (rd_addr[p*ADDR_W +: ADDR_W] == '0))) begin
                    rd_data[p*DATA_W +: DATA_W] = fwd_data[k*DATA_W +: DATA_W];
                    // Load data is not available yet at this stage; forwarded value is don't-care.
                    port_haz[p] = is_load_q[k] && (k < int'(LOAD_LAT));
                end
            end
        end
    end

    // Stall request only counts for ports actually used; a flush kills the request.
    assign ld_hazard = (|(port_haz & rd_en)) & ~flush;

    // Tracker shift: flush clears, stall holds, otherwise a new entry (or bubble) enters EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                valid_q[k]   <= 1'b0;
                dst_q[k]     <= '0;
                we_n_q[k]    <= 1'b1;
                is_load_q[k] <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                valid_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = int'(FWD_DEPTH) - 1; k >= 1; k--) begin
                valid_q[k]   <= valid_q[k-1];
                dst_q[k]     <= dst_q[k-1];
                we_n_q[k]    <= we_n_q[k-1];
                is_load_q[k] <= is_load_q[k-1];
            end
            valid_q[0]   <= issue_en & ~ld_hazard;
            dst_q[0]     <= issue_dst_addr;
            we_n_q[0]    <= issue_gpr_we_;
            is_load_q[0] <= issue_is_load;
        end
    end

    // Saturating count of cycles with an active stall request; clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (ld_hazard && (stall_cnt_q != CntMax)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/id_hazard_fwd_unit.md
Name: id_hazard_fwd_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the decode stage.
- Replaces fixed two-source (EX/MEM) forwarding with an in-flight scoreboard of FWD_DEPTH post-ID stages, NUM_RD read ports and a configurable load latency.
- Sits between the GPR read bus and the decoder.
- Supplies resolved operands, a stall request, and a saturating stall-cycle performance counter.

Parameters:
DATA_W, 32, operand width
ADDR_W, 5, GPR address width
NUM_RD, 2, number of operand read ports
FWD_DEPTH, 3, tracked stages after ID (entry 0 = EX); must be >= 1
LOAD_LAT, 1, lowest entry index at which load data is valid in fwd_data; 0 <= LOAD_LAT <= FWD_DEPTH
ZERO_REG, 1, 1 = address 0 is hardwired zero: never matched, never stalls
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
stall  input  1  pipeline stall; tracker holds
flush  input  1  pipeline flush; tracker invalidated
issue_en  input  1  ID issues an instruction this cycle
issue_dst_addr  input  ADDR_W  destination register of the issuing instruction
issue_gpr_we_  input  1  GPR write enable of the issuing instruction, active-low
issue_is_load  input  1  issuing instruction is a load
rd_en  input  NUM_RD  per-port operand used
rd_addr  input  NUM_RD*ADDR_W  per-port source address; port p at [p*ADDR_W +: ADDR_W]
rd_gpr_data  input  NUM_RD*DATA_W  register-file read data per port
fwd_data  input  FWD_DEPTH*DATA_W  result held at tracked stage k, slice k
rd_data  output  NUM_RD*DATA_W  resolved operand per port
ld_hazard  output  1  load-use stall request
stall_cnt  output  CNT_W  saturating count of hazard cycles
cnt_clr  input  1  synchronous clear of stall_cnt

Behaviour:
- Tracker: FWD_DEPTH entries {valid, dst, we_, is_load}.
- Reset: all valid=0; stall_cnt=0. Consequently ld_hazard=0 and rd_data=rd_gpr_data.
- Rising edge, tracker update, by priority:
  - flush: all valid <= 0. Flush wins over stall.
  - stall: hold all entries.
  - otherwise: entry[k] <= entry[k-1] for k >= 1.
  - otherwise: entry[0] <= {issue_en & ~ld_hazard, issue_dst_addr, issue_gpr_we_, issue_is_load}. A hazard inserts a bubble.
- The oldest entry is discarded on shift.
- Match, per port p, combinational: entry k matches when valid & ~we_ & dst==rd_addr[p] & ~(ZERO_REG & rd_addr[p]==0).
- Youngest match (lowest k) wins; older matches are ignored.
- Port p resolution:
  - no match: rd_data[p] = rd_gpr_data[p].
  - match k, not a load, or load with k >= LOAD_LAT: rd_data[p] = fwd_data[k].
  - match k, load with k < LOAD_LAT: port hazard; rd_data[p] = fwd_data[k], don't care.
- ld_hazard = OR over p of (rd_en[p] & port hazard). Same cycle as rd_addr, zero latency.
- ld_hazard is not masked by stall. It is masked by flush, i.e. forced to 0 during flush.
- A load at entry 0 with LOAD_LAT=1 stalls a dependent exactly 1 cycle; LOAD_LAT=L gives L-k stall cycles.
- LOAD_LAT=0: loads never stall.
- stall_cnt, rising edge, by priority:
  - cnt_clr: stall_cnt <= 0. cnt_clr wins over increment.
  - ld_hazard=1: increment, saturating at 2^CNT_W-1 (no wrap).
- No state depends on rd_gpr_data or fwd_data. The block is purely address and control tracking.
- rst asserted mid-operation clears the tracker and counter immediately (asynchronously). The first post-reset cycle has no forwarding.

Test Plan:
- ALU then dependent:
  - Stimulus: issue dst=3, we_=0, not load. Next cycle rd_en[0]=1, rd_addr[0]=3, fwd_data[0]=0x1234.
  - Required: rd_data[0]=0x1234, ld_hazard=0.
- Load-use, LOAD_LAT=1:
  - Stimulus: issue load dst=5. Next cycle port 1 reads r5.
  - Required: ld_hazard=1 for exactly 1 cycle, bubble enters entry 0, stall_cnt=1.
  - Following cycle: rd_data[1]=fwd_data[1], ld_hazard=0.
- Multiple matches and r0:
  - Stimulus: r7 written at entries 0 and 2, with fwd_data[0]=0xA, fwd_data[2]=0xB.
  - Required: rd_data=0xA.
  - Stimulus: an instruction writing r0 is in flight; read r0 with rd_gpr_data=0.
  - Required: rd_data=0, no hazard.
- Stall and flush:
  - Stimulus: stall=1 for 3 cycles with dst=4 at entry 1.
  - Required: reads of r4 keep forwarding fwd_data[1].
  - Stimulus: flush together with stall.
  - Required: next cycle no matches; rd_data=rd_gpr_data.
- Counter:
  - Stimulus: CNT_W=4, hold a hazard 20 cycles via repeated load-use.
  - Required: stall_cnt saturates at 15.
  - Stimulus: cnt_clr with hazard high.
  - Required: stall_cnt=0.
- Async reset:
  - Stimulus: drop rst between edges while a load-use hazard is active.
  - Required: ld_hazard=0 and stall_cnt=0 immediately; rd_data follows rd_gpr_data.
